wid_chk_for_axi3: RTL

//  Slave-side counterpart to the AXI4->AXI3 WID generator. Sits on the pad

---
 rtl/wid_chk_pkg.sv | 18 +
 rtl/wid_chk_fifo.sv | 67 ++++++
 rtl/wid_chk_for_axi3.sv | 134 +++++++++++++
 3 files changed

// File: rtl/wid_chk_pkg.sv
// Shared types and constants for the AXI3 WID checker.
//  aw_entry_t : one outstanding write-address record {id, len}
//  PTR_W      : FIFO pointer width for the default depth
//  CNT_W      : FIFO occupancy width for the default depth (holds 0..DEPTH)
package wid_chk_pkg;

  localparam int DEPTH_DEF = 32;
  localparam int ID_W_DEF  = 8;
  localparam int LEN_W_DEF = 8;
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [LEN_W_DEF-1:0] len;
  } aw_entry_t;

endpackage

// File: rtl/wid_chk_fifo.sv
// In-order register FIFO holding outstanding AW records.
//  per_clk, pad_cpu_rst_b : clock, async active-low reset
//  push, push_data        : write an entry at the tail (ignored when full)
//  pop                    : drop the head entry (ignored when empty)
//  head                   : entry at the head, valid when !empty
//  full, empty, count     : occupancy status; count spans 0..DEPTH
module wid_chk_fifo
  import wid_chk_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = ID_W_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          per_clk,
  input  logic          pad_cpu_rst_b,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Power-of-2 depth: pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wid_chk_for_axi3.sv
// Slave-side WID checker: accepts AXI3 write traffic carrying WID and feeds
// an AXI4 write slave. Each accepted AW is queued in order; W beats are only
// let through while an AW is outstanding, each beat's WID is compared with
// the head AW id, and the head is retired on WLAST. WID is not forwarded.
//  per_clk, pad_cpu_rst_b          : clock, async active-low reset
//  s_aw* / m_aw*                   : AW handshake master->checker->slave
//  s_w* / m_w*                     : W handshake master->checker->slave
//  wid_err_clr                     : clears the sticky error flags
//  wid_err                         : sticky, a beat carried the wrong WID
//  wlast_err                       : sticky, WLAST misplaced vs AWLEN
//  aw_fifo_full, aw_outstanding    : outstanding-AW queue status
// Build option: define WID_CHK_LEN_EN to store AWLEN and check WLAST
// placement; otherwise only ids are stored and wlast_err is tied low.
module wid_chk_for_axi3
  import wid_chk_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ID_W  = ID_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                   per_clk,
  input  logic                   pad_cpu_rst_b,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [ID_W-1:0]        s_awid,
  input  logic [LEN_W-1:0]       s_awlen,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  input  logic [ID_W-1:0]        s_wid,
  input  logic                   s_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic                   wid_err_clr,
  output logic                   wid_err,
  output logic                   wlast_err,
  output logic                   aw_fifo_full,
  output logic [$clog2(DEPTH):0] aw_outstanding
);

`ifdef WID_CHK_LEN_EN
  localparam int EW = ID_W + LEN_W;
`else
  localparam int EW = ID_W;
`endif

  logic          full, empty, push, beat, pop;
  logic [EW-1:0] push_data, head;
  logic [ID_W-1:0] head_id;
  logic          id_evt;
  logic          wid_err_q, wid_err_d;

  // Handshakes are also gated by reset so every output reads 0 while reset
  // is held, whatever the upstream drives.
  assign m_awvalid = pad_cpu_rst_b & s_awvalid & ~full;
  assign s_awready = pad_cpu_rst_b & m_awready & ~full;
  assign m_wvalid  = pad_cpu_rst_b & s_wvalid  & ~empty;
  assign s_wready  = pad_cpu_rst_b & m_wready  & ~empty;

  assign push = m_awvalid & m_awready;
  assign beat = s_wvalid & s_wready;
  assign pop  = beat & s_wlast;

`ifdef WID_CHK_LEN_EN
  assign push_data = {s_awid, s_awlen};
`else
  assign push_data = s_awid;
  logic unused_len;
  assign unused_len = ^s_awlen;
`endif

  assign head_id = head[EW-1 -: ID_W];
  assign id_evt  = beat & (s_wid != head_id);

  wid_chk_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .per_clk       (per_clk),
    .pad_cpu_rst_b (pad_cpu_rst_b),
    .push          (push),
    .push_data     (push_data),
    .pop           (pop),
    .head          (head),
    .full          (full),
    .empty         (empty),
    .count         (aw_outstanding)
  );

  assign aw_fifo_full = full;

  // Sticky flag: a new event in the clear cycle wins over the clear.
  always_comb begin
    wid_err_d = (wid_err_q & ~wid_err_clr) | id_evt;
  end

`ifdef WID_CHK_LEN_EN
  logic [LEN_W-1:0] head_len;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             len_hit, len_evt;
  logic             wlast_err_q, wlast_err_d;

  assign head_len = head[LEN_W-1:0];
  assign len_hit  = (beat_cnt_q == head_len);
  // WLAST must land exactly on beat index AWLEN.
  assign len_evt  = beat & (s_wlast ? ~len_hit : len_hit);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat) beat_cnt_d = s_wlast ? '0 : beat_cnt_q + LEN_W'(1);
    wlast_err_d = (wlast_err_q & ~wid_err_clr) | len_evt;
  end

  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  assign wlast_err = wlast_err_q;
`else
  assign wlast_err = 1'b0;
`endif

  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) wid_err_q <= 1'b0;
    else                wid_err_q <= wid_err_d;
  end

  assign wid_err = wid_err_q;

endmodule
